// File: rtl/reg_file_stream_reader_if.sv
// reg_file_stream_reader_if: command, register-file read port and output stream of the burst reader.
interface reg_file_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_NUMBER = 8
);
  localparam int ADDR_W = $clog2(REG_NUMBER);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_base;
  logic [ADDR_W:0]       cmd_len;
  logic                  rf_en_r;
  logic [ADDR_W-1:0]     rf_addr_r;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  modport master (
    input  cmd_valid, cmd_base, cmd_len, rf_data, m_ready,
    output cmd_ready, rf_en_r, rf_addr_r, m_valid, m_data, m_last
  );
  modport slave (
    output cmd_valid, cmd_base, cmd_len, rf_data, m_ready,
    input  cmd_ready, rf_en_r, rf_addr_r, m_valid, m_data, m_last
  );
endinterface

// File: rtl/reg_file_stream_reader.sv
// reg_file_stream_reader: burst-reads consecutive register-file entries and streams them out
// through a 2-entry buffer that absorbs the 1-cycle read latency and downstream backpressure.
module reg_file_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_NUMBER = 8
) (
  input  logic clk,
  input  logic rst_n,
  reg_file_stream_reader_if.master bus,
  output logic busy,
  output logic done
);
  localparam int ADDR_W = $clog2(REG_NUMBER);
  localparam logic [ADDR_W:0] RN = (ADDR_W+1)'(REG_NUMBER);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_NUMBER - 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                state;
  logic [ADDR_W:0]       remaining;
  logic [ADDR_W:0]       len_c;
  logic [ADDR_W-1:0]     nxt_addr;
  logic [ADDR_W-1:0]     addr_q;
  logic [1:0]            count;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  pop;
  logic                  accept;
  logic                  last_pop;
  logic [2:0]            occ;
  logic [DATA_WIDTH:0]   buf_q [2];
  assign accept = bus.cmd_valid && state == IDLE;
  assign len_c = bus.cmd_len > RN ? RN : bus.cmd_len;
  assign pop = bus.m_valid && bus.m_ready;
  assign last_pop = state == DRAIN && pop && bus.m_last;
  // occupancy the buffer would have after this cycle's pop, counting the read already in flight
  assign occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign bus.rf_en_r = state == READ && remaining != '0 && occ < 3'd2;
  assign bus.rf_addr_r = bus.rf_en_r ? nxt_addr : addr_q;
  assign bus.cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign bus.m_valid = count != 2'd0;
  assign {bus.m_last, bus.m_data} = buf_q[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      nxt_addr <= '0;
      addr_q <= '0;
      count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      done <= 1'b0;
    end else begin
      done <= (accept && len_c == '0) || last_pop;
      inflight_q <= bus.rf_en_r;
      inflight_last_q <= bus.rf_en_r && remaining == ONE;
      count <= count + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) begin
        buf_q[wr_ptr] <= {inflight_last_q, bus.rf_data};
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      if (accept) begin
        nxt_addr <= bus.cmd_base;
        remaining <= len_c;
        if (len_c != '0) state <= READ;
      end
      if (bus.rf_en_r) begin
        addr_q <= nxt_addr;
        nxt_addr <= nxt_addr == LAST ? '0 : nxt_addr + 1'b1;
        remaining <= remaining - 1'b1;
        if (remaining == ONE) state <= DRAIN;
      end
      if (last_pop) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_reg_file_stream_reader.sv
// tb_reg_file_stream_reader: table of bursts plus hand-written corner sequences, checked
// against a scoreboard of expected read addresses and output beats.
module tb_reg_file_stream_reader;
  localparam int DW = 16;
  localparam int RN = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done;
  int tests = 0;
  int fails = 0;
  int mode_r = 0;
  int cyc = 0;
  int beats_seen = 0;
  int outstanding = 0;
  logic stall_prev = 1'b0;
  logic [DW:0] held;
  logic [DW:0] exp_q [$];
  int addr_q [$];
  typedef struct {int base; int len; int mode; int first; int dn;} vec_t;
  vec_t vecs [7];
  reg_file_stream_reader_if #(.DATA_WIDTH(DW), .REG_NUMBER(RN)) bus ();
  reg_file_stream_reader #(.DATA_WIDTH(DW), .REG_NUMBER(RN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rf_en_r) bus.rf_data <= DW'(16'h100 + bus.rf_addr_r);
  always @(posedge clk) begin
    #1;
    cyc++;
    bus.m_ready = (mode_r == 0) || (cyc % 3 == 0);
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      stall_prev = 1'b0;
    end else begin
      if (bus.rf_en_r) begin
        check("rd_room", 32'(outstanding - int'(bus.m_valid && bus.m_ready) < 2), 32'd1);
        if (addr_q.size() == 0) check("rd_unexpected", 32'(bus.rf_addr_r), 32'hffff_ffff);
        else check("rd_addr", 32'(bus.rf_addr_r), 32'(addr_q.pop_front()));
      end
      if (stall_prev && bus.m_valid) check("stall_stable", 32'({bus.m_last, bus.m_data}), 32'(held));
      if (bus.m_valid && bus.m_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) check("beat_unexpected", 32'({bus.m_last, bus.m_data}), 32'hffff_ffff);
        else check("beat", 32'({bus.m_last, bus.m_data}), 32'(exp_q.pop_front()));
      end
      outstanding = outstanding + int'(bus.rf_en_r) - int'(bus.m_valid && bus.m_ready);
      stall_prev = bus.m_valid && !bus.m_ready;
      held = {bus.m_last, bus.m_data};
    end
  end
  task automatic push_exp(input int base, input int len);
    int n;
    n = len > RN ? RN : len;
    for (int i = 0; i < n; i++) begin
      addr_q.push_back((base + i) % RN);
      exp_q.push_back({i == n - 1, DW'(16'h100 + (base + i) % RN)});
    end
  endtask
  task automatic check_rst(input string name);
    check(name, 32'({bus.cmd_ready, bus.rf_en_r, bus.rf_addr_r, bus.m_valid, bus.m_data, bus.m_last, busy, done}),
          32'({1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}));
  endtask
  // entered in cycle 1 after acceptance; returns one cycle after the done pulse
  task automatic wait_burst(input int first, input int dn);
    int k, f;
    f = 0;
    for (k = 1; k < 200; k++) begin
      if (bus.m_valid && f == 0) f = k;
      if (done) break;
      @(posedge clk); #1;
    end
    check("done_timeout", 32'(k < 200), 32'd1);
    if (dn != 0) check("done_cycle", 32'(k), 32'(dn));
    check("first_valid", 32'(f), 32'(first));
    check("done_idle", 32'({busy, bus.cmd_ready}), 32'b01);
    check("sb_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
  endtask
  task automatic run_cmd(input int base, input int len, input int mode, input int first, input int dn);
    mode_r = mode;
    bus.cmd_base = 3'(base);
    bus.cmd_len = 4'(len);
    bus.cmd_valid = 1'b1;
    push_exp(base, len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_burst(first, dn);
  endtask
  initial begin
    int k, b0;
    vecs[0] = '{2, 4, 0, 3, 7};
    vecs[1] = '{6, 5, 0, 3, 8};
    vecs[2] = '{0, 6, 1, 3, 0};
    vecs[3] = '{3, 0, 0, 0, 1};
    vecs[4] = '{1, 12, 0, 3, 11};
    vecs[5] = '{7, 1, 0, 3, 4};
    vecs[6] = '{0, 8, 1, 3, 0};
    bus.cmd_valid = 1'b0;
    bus.cmd_base = '0;
    bus.cmd_len = '0;
    bus.m_ready = 1'b1;
    bus.rf_data = '0;
    #1;
    check_rst("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_rst("reset_idle");
    foreach (vecs[i]) run_cmd(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].first, vecs[i].dn);
    mode_r = 0;
    bus.cmd_base = 3'd0;
    bus.cmd_len = 4'd2;
    bus.cmd_valid = 1'b1;
    push_exp(0, 2);
    @(posedge clk); #1;
    bus.cmd_base = 3'd4;
    bus.cmd_len = 4'd3;
    for (k = 1; k < 50; k++) begin
      if (done) break;
      check("b2b_blocked", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("b2b_done", 32'({done, bus.cmd_ready}), 32'b11);
    push_exp(4, 3);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_burst(3, 6);
    bus.cmd_base = 3'd0;
    bus.cmd_len = 4'd6;
    bus.cmd_valid = 1'b1;
    push_exp(0, 6);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    b0 = beats_seen;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (beats_seen - b0 >= 2) break;
    end
    check("mid_beats", 32'(beats_seen - b0 >= 2), 32'd1);
    @(posedge clk); #2;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_rst("reset_mid");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_rst("reset_release");
    run_cmd(5, 2, 0, 3, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
